// File: rtl/mor1kx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mor1kx_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Words are kept in
//               a dual-port array with a registered read port that feeds a
//               head output register. The head is refilled whenever it is
//               empty or being consumed, so a consumer holding rd_ready high
//               drains one word per cycle with no bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module mor1kx_sync_fifo #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  output logic [DEPTH_WIDTH:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int                 c_DEPTH   = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_CAP   = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] c_CNT_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH-1:0] c_PTR_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  // Storage array; contents are never reset.
  logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];

  // Write pointer: next free slot. Read pointer: next array word to move
  // into the head register.
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;

  // Total occupancy, head register included.
  logic [DEPTH_WIDTH:0]   r_count;

  // Head output register.
  logic                   r_head_valid;
  logic [DATA_WIDTH-1:0]  r_head_data;

  logic                   w_wr_ready;
  logic                   w_push;
  logic                   w_pop;
  logic [DEPTH_WIDTH:0]   w_arr_cnt;
  logic                   w_arr_avail;
  logic                   w_prefetch;
  logic                   w_bypass;

  // Handshake qualification. wr_ready comes only from the registered count,
  // so it never has a combinational path from rd_ready.
  assign w_wr_ready = (r_count != c_CAP);
  assign w_push     = wr_valid && w_wr_ready && !flush;
  assign w_pop      = r_head_valid && rd_ready && !flush;

  // Words sitting in the array that have not yet moved into the head. The
  // head is refilled eagerly, so this is at most CAP-1 and the pointers are
  // equal exactly when it is zero.
  assign w_arr_cnt   = r_count - {{DEPTH_WIDTH{1'b0}}, r_head_valid};
  assign w_arr_avail = (w_arr_cnt != '0);

  // Refill the head when it is empty or leaving this cycle and a word exists,
  // either already in the array or arriving on the write port right now.
  assign w_prefetch = !flush && (!r_head_valid || w_pop) && (w_arr_avail || w_push);

  // Write and prefetch hitting the same slot: take the incoming word directly.
  assign w_bypass = w_push && (r_wr_ptr == r_rd_ptr);

  // Array write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Registered read port feeding the head register; data only changes on a
  // refill, so it holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else if (flush) begin
      r_head_valid <= 1'b0;
    end else if (w_prefetch) begin
      r_head_valid <= 1'b1;
      r_head_data  <= w_bypass ? wr_data : r_mem[r_rd_ptr];
    end else if (w_pop) begin
      r_head_valid <= 1'b0;
    end
  end

  // Pointer advance; both wrap modulo the array depth by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_prefetch) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Occupancy tracking; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_valid = r_head_valid;
  assign rd_data  = r_head_data;
  assign count    = r_count;
  assign full     = (r_count == c_CAP);
  assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: doc/mor1kx_sync_fifo.md
MOR1KX_SYNC_FIFO -- requirements
Module: mor1kx_sync_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_WIDTH, default 4, giving capacity CAP = 2^DEPTH_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all contents.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: the producer offers wr_data.
REQ-007 The block SHALL have port wr_data, input, DATA_WIDTH bits: the write word.
REQ-008 The block SHALL have port wr_ready, output, 1 bit: the FIFO can accept a word.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: rd_data holds the oldest word.
REQ-010 The block SHALL have port rd_data, output, DATA_WIDTH bits: the head word (first-word-fall-through).
REQ-011 The block SHALL have port rd_ready, input, 1 bit: the consumer takes the head word.
REQ-012 The block SHALL have port count, output, DEPTH_WIDTH+1 bits: the number of words held.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each: count==CAP and count==0.

Function
REQ-014 Storage SHALL be a synchronous-read dual-port array: one write port and one registered read port, with the read enabled only when prefetching, plus a head output register.
REQ-015 A push SHALL occur on an edge where wr_valid && wr_ready && !flush.
REQ-016 A pop SHALL occur on an edge where rd_valid && rd_ready && !flush.
REQ-017 wr_ready SHALL equal !full and SHALL depend only on registered state, never on rd_ready.
REQ-018 rd_valid SHALL be a registered output, and rd_data SHALL be stable while rd_valid && !rd_ready.
REQ-019 Count SHALL update per edge: +1 on push only, -1 on pop only, unchanged on push+pop, 0 on flush.
REQ-020 Count SHALL never exceed CAP or go below 0, and full and empty SHALL track the updated count in the same cycle.
REQ-021 Write-to-read latency when the FIFO is empty SHALL be 1: a word pushed on edge k gives rd_valid=1 with that word after edge k.
REQ-022 When the head register is occupied, the next word SHALL be prefetched from the array so that back-to-back pops with rd_ready held high sustain one word per cycle with no bubble.
REQ-023 A push and a prefetch read of the same array address in one cycle SHALL return the newly written word (write-first bypass).
REQ-024 Words SHALL emerge in exact push order with no loss or duplication, including across pointer wrap-around.
REQ-025 Read and write pointers SHALL be DEPTH_WIDTH bits wide and wrap modulo CAP.
REQ-026 Push and pop on the same edge at count==1 SHALL deliver the new word as the head on the following cycle, with count remaining 1.
REQ-027 Push and pop on the same edge at count==CAP SHALL be impossible, because wr_ready is 0; a pop at full SHALL raise wr_ready on the next cycle.
REQ-028 A pop at count==0 SHALL be impossible, because rd_valid is 0; rd_ready while empty SHALL have no effect.
REQ-029 flush SHALL override push and pop in the same cycle; after that edge, count=0, rd_valid=0, wr_ready=1, and both pointers SHALL equal each other.

Reset
REQ-030 While rst=1, asynchronously: count=0, empty=1, full=0, wr_ready=1, rd_valid=0, rd_data=0, pointers=0.
REQ-031 Array contents SHALL NOT require reset.
REQ-032 Reset asserted mid-transfer SHALL discard all words, and the first push after release SHALL be the first word read.

Verification
REQ-033 The bench SHALL cover: reset, then push 0xA5A5A5A5 at edge 1 -> rd_valid=1, rd_data=0xA5A5A5A5, count=1 after edge 1.
REQ-034 The bench SHALL cover: push 0..15 with DEPTH_WIDTH=4 and no pops -> full=1, wr_ready=0, count=16; a 17th wr_valid is ignored; a pop then gives wr_ready=1, count=15.
REQ-035 The bench SHALL cover: fill with 0..15, then hold rd_ready=1 -> 16 consecutive cycles of rd_valid=1 with data 0..15 in order, then empty=1.
REQ-036 The bench SHALL cover: at count==1 with head 7, push 8 and pop 7 on the same edge -> head=8, count=1.
REQ-037 The bench SHALL cover: count=5, then flush with wr_valid=1 and rd_ready=1 -> count=0, rd_valid=0; the next push 0x3C gives head 0x3C.
REQ-038 The bench SHALL cover: 1000 random push/pop cycles with wrap-around, checked against a reference queue -> identical order, count matches, and wr_ready is never 1 while full.
